// File: rtl/fd_video_pkg.sv
// Shared video definitions: tile word field layout, map geometry, bus widths,
// and the decoded tile record used by the playfield fetcher.
package fd_video_pkg;

    localparam int TILE_W   = 8;
    localparam int MAP_COLS = 32;
    localparam int MAP_ROWS = 32;

    localparam int PF_AW  = 10;
    localparam int ROM_AW = 12;
    localparam int PIX_W  = 8;

    // Tile word field positions
    localparam int TW_CODE_LO_MSB = 7;
    localparam int TW_CODE_HI     = 15;
    localparam int TW_COLOR_MSB   = 13;
    localparam int TW_COLOR_LSB   = 8;
    localparam int TW_HFLIP       = 14;

    typedef struct packed {
        logic [8:0] code;
        logic [5:0] color;
        logic       hflip;
    } tile_t;

    function automatic tile_t decode_tile(input logic [15:0] w);
        tile_t t;
        t.code  = {w[TW_CODE_HI], w[TW_CODE_LO_MSB:0]};
        t.color = w[TW_COLOR_MSB:TW_COLOR_LSB];
        t.hflip = w[TW_HFLIP];
        return t;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/pf_tile_fetch_if.sv
// Playfield RAM read port and graphics ROM port as seen by the tile fetcher.
interface pf_tile_fetch_if;
    import fd_video_pkg::*;

    logic [PF_AW-1:0]  pf_a;
    logic              pf_r;
    logic [15:0]       pf_d;
    logic [ROM_AW-1:0] rom_a;
    logic              rom_r;
    logic [15:0]       rom_d;

    modport master (output pf_a, pf_r, rom_a, rom_r, input pf_d, rom_d);
    modport slave  (input pf_a, pf_r, rom_a, rom_r, output pf_d, rom_d);
endinterface

// File: rtl/pf_shifter2.sv
// Two-plane 8-bit load/shift register with colour and registered pixel output.
// Load replaces the shift on the enable it occurs; blanking forces a zero pixel.
module pf_shifter2
    import fd_video_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             load,
    input  logic [7:0]       nxt_p1,
    input  logic [7:0]       nxt_p0,
    input  logic [5:0]       nxt_color,
    input  logic             blank,
    output logic [PIX_W-1:0] pix,
    output logic             opaque
);

    logic [7:0] p1, p0;
    logic [5:0] color;

    // Load a new tile row at slot 7, otherwise shift MSB-first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1    <= '0;
            p0    <= '0;
            color <= '0;
        end else if (ce) begin
            if (load) begin
                p1    <= nxt_p1;
                p0    <= nxt_p0;
                color <= nxt_color;
            end else begin
                p1 <= {p1[6:0], 1'b0};
                p0 <= {p0[6:0], 1'b0};
            end
        end
    end

    // Registered pixel output, zeroed while blanked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix    <= '0;
            opaque <= 1'b0;
        end else if (ce) begin
            pix    <= blank ? '0 : {color, p1[7], p0[7]};
            opaque <= !blank && (p1[7] || p0[7]);
        end
    end

endmodule

// File: rtl/pf_tile_fetch.sv
// Playfield tile fetcher: walks the 32x32 tile map one tile ahead of the beam,
// fetches the 2bpp graphics row and shifts pixels to the mixer.
// Optional horizontal flip is built when PF_HFLIP_EN is defined.
module pf_tile_fetch
    import fd_video_pkg::*;
#(
    parameter int HOFS = 0,
    parameter int VOFS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_ce,
    input  logic [8:0]       hcount,
    input  logic [8:0]       vcount,
    input  logic             hblank,
    input  logic             vblank,
    pf_tile_fetch_if.master  bus,
    output logic [PIX_W-1:0] pf_pix,
    output logic             pf_opaque
);

    logic [2:0] slot;
    logic [4:0] col, row;
    logic [7:0] eff;
    logic [2:0] line;
    tile_t      tw;

    assign slot = hcount[2:0];
    // Column and line arithmetic wrap naturally at the map/line widths
    assign col  = hcount[7:3] + 5'd1 + 5'(HOFS);
    assign eff  = vcount[7:0] + 8'(VOFS);
    assign row  = eff[7:3];
    assign line = eff[2:0];
    assign tw   = decode_tile(bus.pf_d);

    logic [5:0] color_q;
    logic [7:0] nxt_p1, nxt_p0;
    logic [5:0] nxt_color;
    logic [7:0] plane1_in, plane0_in;

`ifdef PF_HFLIP_EN
    logic hflip_q;

    // Capture the flip attribute alongside the tile colour
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        hflip_q <= 1'b0;
        else if (pix_ce && slot == 3'd2)  hflip_q <= tw.hflip;
    end

    assign plane1_in = hflip_q ? rev8(bus.rom_d[15:8]) : bus.rom_d[15:8];
    assign plane0_in = hflip_q ? rev8(bus.rom_d[7:0])  : bus.rom_d[7:0];
`else
    assign plane1_in = bus.rom_d[15:8];
    assign plane0_in = bus.rom_d[7:0];
`endif

    // Bits that the address math or default build deliberately drop
    logic unused_ok;
    assign unused_ok = ^{1'b0, hcount[8], vcount[8], tw.hflip};

    // Slot sequencing: tile address at slot 0, ROM address at slot 2; strobes last one clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pf_a  <= '0;
            bus.pf_r  <= 1'b0;
            bus.rom_a <= '0;
            bus.rom_r <= 1'b0;
            color_q   <= '0;
        end else begin
            bus.pf_r  <= 1'b0;
            bus.rom_r <= 1'b0;
            if (pix_ce) begin
                case (slot)
                    3'd0: begin
                        bus.pf_a <= {row, col};
                        bus.pf_r <= !vblank;
                    end
                    3'd2: begin
                        bus.rom_a <= {tw.code, line};
                        bus.rom_r <= !vblank;
                        color_q   <= tw.color;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Slot 4: stage the fetched row and its colour for the next load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nxt_p1    <= '0;
            nxt_p0    <= '0;
            nxt_color <= '0;
        end else if (pix_ce && slot == 3'd4) begin
            nxt_p1    <= plane1_in;
            nxt_p0    <= plane0_in;
            nxt_color <= color_q;
        end
    end

    pf_shifter2 u_shift (
        .clk       (clk),
        .reset     (reset),
        .ce        (pix_ce),
        .load      (slot == 3'd7),
        .nxt_p1    (nxt_p1),
        .nxt_p0    (nxt_p0),
        .nxt_color (nxt_color),
        .blank     (hblank || vblank),
        .pix       (pf_pix),
        .opaque    (pf_opaque)
    );

endmodule
